// File: rtl/cr16_seq_ctrl.sv
// Multi-cycle sequencing FSM for the CR16-subset datapath: fetch, decode,
// ALU/load/store/branch sequencing with memory-ready stalls and optional retire limit.
//
// state      | meaning
// FETCH      | drive PC address, latch IR when memory ready
// DECODE     | present decoded fields, choose instruction path
// EXEC       | ALU result writeback, PC+1
// LOAD_ADDR  | present Rsrc address, wait for memory ready
// LOAD_WB    | write memory data to Rdest, PC+1
// STORE      | write data memory at Rsrc, PC+1 when ready
// BRANCH     | evaluate condition, update PC
// HALT       | retire limit reached, sticky until reset
module cr16_seq_ctrl #(
  parameter int NREGS      = 16,
  parameter int FLAG_W     = 5,
  parameter int MAX_INSTRS = 0,
  localparam int RIDX_W    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLAG_W-1:0] flags,
  input  logic [15:0]       instr,
  input  logic              mem_rdy,
  output logic              pc_en,
  output logic [1:0]        pc_sel,
  output logic              ir_en,
  output logic              reg_we,
  output logic [NREGS-1:0]  reg_en,
  output logic              imm_en,
  output logic              wb_sel,
  output logic              addr_sel,
  output logic              mem_we,
  output logic [3:0]        op,
  output logic [RIDX_W-1:0] rdest,
  output logic [RIDX_W-1:0] rsrc,
  output logic [7:0]        imm8,
  output logic              halted
);

  localparam int CNT_W = (MAX_INSTRS > 0) ? $clog2(MAX_INSTRS + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_LOAD_ADDR, S_LOAD_WB, S_STORE, S_BRANCH, S_HALT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             retire, halt_hit, cond_true;

  logic [3:0] opc, sub, alu_op;
  logic       is_rr, is_mem, is_bcc, is_load, is_stor, is_jcc, is_imm;
  logic       flg_n, flg_z, flg_f, flg_l, flg_c;
  logic [NREGS-1:0] rd_onehot;

  assign opc     = instr[15:12];
  assign sub     = instr[7:4];
  assign is_rr   = (opc == 4'h0);
  assign is_mem  = (opc == 4'h4);
  assign is_bcc  = (opc == 4'hC);
  assign is_load = is_mem && (sub == 4'h0);
  assign is_stor = is_mem && (sub == 4'h4);
  assign is_jcc  = is_mem && (sub == 4'hC);
  assign is_imm  = !is_rr && !is_mem && !is_bcc;
  // Memory/branch classes carry no ALU operation; treat them as NOP.
  assign alu_op  = is_rr ? sub : (is_imm ? opc : 4'h0);

  assign {flg_n, flg_z, flg_f, flg_l, flg_c} = flags[4:0];
  assign rd_onehot = {{(NREGS-1){1'b0}}, 1'b1} << instr[8 +: RIDX_W];

  always_comb begin
    case (instr[11:8])
      4'h0: cond_true = flg_z;
      4'h1: cond_true = !flg_z;
      4'h2: cond_true = flg_c;
      4'h3: cond_true = !flg_c;
      4'h4: cond_true = flg_l;
      4'h5: cond_true = !flg_l;
      4'h6: cond_true = flg_n;
      4'h7: cond_true = !flg_n;
      4'h8: cond_true = flg_f;
      4'h9: cond_true = !flg_f;
      4'hA: cond_true = !flg_l && !flg_z;
      4'hB: cond_true = flg_l || flg_z;
      4'hC: cond_true = !flg_n && !flg_z;
      4'hD: cond_true = flg_n || flg_z;
      4'hE: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign cnt_nxt  = cnt + CNT_W'(1);
  assign halt_hit = (MAX_INSTRS > 0) && (cnt_nxt == CNT_W'(MAX_INSTRS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (retire) cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    pc_en     = 1'b0;
    pc_sel    = 2'b00;
    ir_en     = 1'b0;
    reg_we    = 1'b0;
    reg_en    = '0;
    imm_en    = 1'b0;
    wb_sel    = 1'b0;
    addr_sel  = 1'b0;
    mem_we    = 1'b0;
    op        = 4'h0;
    rdest     = '0;
    rsrc      = '0;
    imm8      = 8'h00;
    halted    = 1'b0;

    // Decoded fields stay visible for every post-fetch cycle of an instruction.
    if (state != S_FETCH && state != S_HALT) begin
      op     = alu_op;
      imm_en = is_imm;
      rdest  = instr[8 +: RIDX_W];
      rsrc   = instr[0 +: RIDX_W];
      imm8   = instr[7:0];
    end

    case (state)
      S_FETCH: begin
        // reset gating keeps ir_en low while reset is held
        ir_en = mem_rdy && reset;
        if (mem_rdy) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (is_load)               state_nxt = S_LOAD_ADDR;
        else if (is_stor)          state_nxt = S_STORE;
        else if (is_bcc || is_jcc) state_nxt = S_BRANCH;
        else                       state_nxt = S_EXEC;
      end
      S_EXEC: begin
        pc_en  = 1'b1;
        retire = 1'b1;
        if (alu_op != 4'hB && alu_op != 4'h0) begin
          reg_we = 1'b1;
          reg_en = rd_onehot;
        end
      end
      S_LOAD_ADDR: begin
        addr_sel = 1'b1;
        if (mem_rdy) state_nxt = S_LOAD_WB;
      end
      S_LOAD_WB: begin
        wb_sel = 1'b1;
        reg_we = 1'b1;
        reg_en = rd_onehot;
        pc_en  = 1'b1;
        retire = 1'b1;
      end
      S_STORE: begin
        addr_sel = 1'b1;
        mem_we   = 1'b1;
        pc_en    = mem_rdy;
        retire   = mem_rdy;
      end
      S_BRANCH: begin
        pc_en  = 1'b1;
        retire = 1'b1;
        if (cond_true) pc_sel = is_bcc ? 2'b01 : 2'b10;
      end
      default: begin
        halted = 1'b1;
      end
    endcase

    if (retire) state_nxt = halt_hit ? S_HALT : S_FETCH;
  end

endmodule

// File: doc/cr16_seq_ctrl.md
# cr16_seq_ctrl

Multi-cycle control FSM for the CR16-subset datapath: the parametrised successor of the lab control/decoder. It sequences fetch, decode, ALU execute/writeback, load, store, conditional branch and register jump, and stalls on a memory ready handshake. It has an optional retire limit with a sticky halt. It sits between instruction memory/IR, regfile, ALU, PC unit and data memory.

## Interface
- NREGS, 16: register count; power of 2, 2..16; RIDX_W = $clog2(NREGS)
- FLAG_W, 5: flag vector width; bit map {N,Z,F,L,C} = flags[4:0]
- MAX_INSTRS, 0: retire limit; 0 = unlimited
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears state and counter
- flags  in  FLAG_W  registered PSR flags from the datapath
- instr  in  16  IR contents; memory DOUT during FETCH
- mem_rdy  in  1  memory access completes this cycle
- pc_en  out  1  PC update strobe
- pc_sel  out  2  00 PC+1, 01 PC+sext(disp8), 10 PC<=Rsrc
- ir_en  out  1  IR <= DOUT
- reg_we  out  1  regfile write enable
- reg_en  out  NREGS  one-hot write select
- imm_en  out  1  ALU B = immediate
- wb_sel  out  1  0 ALU result, 1 memory DOUT
- addr_sel  out  1  memory address 0 PC, 1 Rsrc
- mem_we  out  1  data memory write
- op  out  4  ALU opcode
- rdest, rsrc  out  RIDX_W  low RIDX_W bits of instr[11:8] and instr[3:0]
- imm8  out  8  instr[7:0]
- halted  out  1  retire limit reached

## Operation
- States: FETCH, DECODE, EXEC, LOAD_ADDR, LOAD_WB, STORE, BRANCH, HALT.
- Decode of instr[15:12]:
  - 0000: RR; op = instr[7:4], imm_en = 0.
  - 0100: memory/jump class; instr[7:4] selects 0000 LOAD, 0100 STOR, 1100 Jcond; any other value is a NOP.
  - 1100: Bcond.
  - Other values: immediate ALU op; op = instr[15:12], imm_en = 1.
- Conditions come from instr[11:8]:
  - EQ 0000 Z, NE 0001 !Z, CS 0010 C, CC 0011 !C, HI 0100 L, LS 0101 !L, GT 0110 N, LE 0111 !N
  - FS 1000 F, FC 1001 !F, LO 1010 !L&!Z, HS 1011 L|Z, LT 1100 !N&!Z, GE 1101 N|Z
  - UC 1110 always, 1111 never
- FETCH: addr_sel = 0. Hold in FETCH while mem_rdy = 0. When mem_rdy = 1, assert ir_en and go to DECODE.
- DECODE: drive op, rdest, rsrc, imm8, imm_en; no write strobes. Next state:
  - LOAD to LOAD_ADDR
  - STOR to STORE
  - Bcond and Jcond to BRANCH
  - everything else to EXEC
- EXEC: pc_en = 1, pc_sel = 00. Assert reg_we and reg_en = 1 << rdest unless op is CMP (1011) or NOP (0000).
- LOAD_ADDR: addr_sel = 1. Hold while mem_rdy = 0, then go to LOAD_WB.
- LOAD_WB: wb_sel = 1, reg_we = 1, reg_en = 1 << rdest, pc_en = 1, pc_sel = 00.
- STORE: addr_sel = 1 and mem_we = 1 while waiting. On the mem_rdy = 1 cycle also pc_en = 1, pc_sel = 00.
- BRANCH: pc_en = 1. If the condition is true, pc_sel = 01 (Bcond) or 10 (Jcond); otherwise pc_sel = 00. flags are sampled in this cycle. No register write.
- Retire counter: increments on the final cycle of each instruction. When MAX_INSTRS > 0 and the incremented count equals MAX_INSTRS, the next state is HALT instead of FETCH.
- HALT: all strobes 0, halted = 1. HALT is sticky until reset.

## Timing
- Reset (asynchronous, any state, mid-access included): state FETCH, counter 0, halted 0. All strobes and decode fields are 0 from reset assertion through the first FETCH.
- Latency with mem_rdy held at 1:
  - RR/immediate, STOR, branch: 3 cycles
  - LOAD: 4 cycles
- Each cycle of mem_rdy = 0 in FETCH, LOAD_ADDR or STORE adds exactly one cycle. Outputs stay constant during the stall.
- pc_en pulses exactly once per instruction, in the final cycle. ir_en pulses exactly once, in FETCH.
- reg_we is never asserted together with mem_we. Neither is asserted in FETCH, DECODE or HALT.
- Outputs are combinational from state, instr and flags. No output depends on mem_rdy except ir_en in FETCH and pc_en in STORE.

## Test plan
- ADD R3,R1 (instr 0x0351), mem_rdy = 1: reg_we = 1 and reg_en = 0x0008 in cycle 3, pc_en pulses once, then FETCH.
- CMP R2,R4 (0x02B4) then BEQ +5 (0xC005) with flags Z = 1: no reg_we for CMP; in BRANCH, pc_sel = 01. Repeat with Z = 0: pc_sel = 00.
- LOAD R5,[R2] (0x4502), mem_rdy low for 2 cycles in LOAD_ADDR: 6-cycle instruction; LOAD_WB has wb_sel = 1, reg_en = 0x0020.
- STOR (0x4742), mem_rdy low for 1 cycle: mem_we high for 2 cycles, pc_en only on the second, reg_we = 0 throughout.
- MAX_INSTRS = 3 with three MOVI instructions: halted rises after the third retire and stays high; pc_en stays 0 in HALT.
- NREGS = 8 with rdest field 0xB: reg_en = 0x08. Assert reset mid-LOAD_ADDR: outputs 0 immediately, restart at FETCH.
